// File: rtl/fetch_inst_queue.sv
// rtl/fetch_inst_queue.sv - circular instruction queue between fetch and the IF/ID register (optional FETCH_QUEUE_BYPASS_EN)
module fetch_inst_queue #(
   parameter int DEPTH      = 4,
   parameter int PC_WIDTH   = 32,
   parameter int INST_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [PC_WIDTH-1:0]          in_pc,
   input  logic [INST_WIDTH-1:0]        in_inst,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [PC_WIDTH-1:0]          out_pc,
   output logic [INST_WIDTH-1:0]        out_inst,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];
   logic [INST_WIDTH-1:0] inst_mem_q [DEPTH];

   logic full;
   logic empty;
   logic push;
   logic pop;
   logic bypass_take;
   logic bypass_consume;
   logic wr_en;

   // Occupancy flags come from the registered counter only, so in_ready
   // never sees out_ready.
   always_comb begin
      full  = (count_q == CNT_W'(DEPTH));
      empty = (count_q == '0);
   end

   // Output side: head entry, or the incoming word when passing straight through an empty queue.
   always_comb begin
      in_ready = !full;
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass_take = empty && in_valid && !flush;
      out_valid   = !flush && (!empty || in_valid);
      out_pc      = bypass_take ? in_pc   : pc_mem_q[head_q];
      out_inst    = bypass_take ? in_inst : inst_mem_q[head_q];
`else
      bypass_take = 1'b0;
      out_valid   = !empty;
      out_pc      = pc_mem_q[head_q];
      out_inst    = inst_mem_q[head_q];
`endif
      count = count_q;
   end

   // Handshake qualification; a bypassed word that is taken the same cycle never occupies storage.
   always_comb begin
      push           = in_valid && in_ready;
      pop            = out_valid && out_ready;
      bypass_consume = bypass_take && out_ready;
      wr_en          = push && !flush && !bypass_consume;
   end

   // Pointer and occupancy next state; flush wins over any handshake in the same cycle.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else if (!bypass_consume) begin
         if (push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // Pointer/counter registers; reset drops every entry immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; cleared on reset so the head reads as zero while empty after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         pc_mem_q[tail_q]   <= in_pc;
         inst_mem_q[tail_q] <= in_inst;
      end
   end

endmodule

// File: tb/tb_fetch_inst_queue.sv
// tb/tb_fetch_inst_queue.sv - randomized and directed bench for fetch_inst_queue against a queue model
module tb_fetch_inst_queue;

   localparam int DEPTH = 4;
   localparam int PW    = 32;
   localparam int IW    = 32;
   localparam int CW    = $clog2(DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [PW-1:0] in_pc;
   logic [IW-1:0] in_inst;
   logic          out_valid;
   logic          out_ready;
   logic [PW-1:0] out_pc;
   logic [IW-1:0] out_inst;
   logic [CW-1:0] count;

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] q[$];
   bit          held;

   fetch_inst_queue #(.DEPTH(DEPTH), .PC_WIDTH(PW), .INST_WIDTH(IW)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic bit bypass_on();
`ifdef FETCH_QUEUE_BYPASS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs against the model, advance the model, cross the edge.
   task automatic step();
      bit          bp;
      bit          exp_valid;
      bit          push;
      bit          pop;
      logic [63:0] exp_head;
      #1;
      bp        = bypass_on() && (q.size() == 0) && in_valid && !flush;
      exp_valid = bp || (q.size() != 0);
      if (bypass_on() && flush) exp_valid = 1'b0;
      exp_head  = bp ? {in_pc, in_inst} : (q.size() != 0 ? q[0] : 64'd0);
      chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("count", 64'(count), 64'(q.size()));
      if (exp_valid) chk("out_head", {out_pc, out_inst}, exp_head);
      push = in_valid && (q.size() < DEPTH);
      pop  = exp_valid && out_ready;
      held = in_valid && !push && !flush;
      if (flush) begin
         q.delete();
      end else if (!(bp && out_ready)) begin
         if (pop) void'(q.pop_front());
         if (push) q.push_back({in_pc, in_inst});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_pc = '0; in_inst = '0; held = 1'b0;
      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_pc", 64'(out_pc), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // fill to full with the consumer stalled, then hold a fifth word
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_pc = 32'h100 + 32'(4*i); in_inst = $urandom;
         step();
      end
      in_pc = 32'h110; in_inst = 32'hDEAD_0110;
      step();
      chk("full_count", 64'(count), 64'd4);
      chk("full_out_pc", 64'(out_pc), 64'h100);

      // drain everything
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) step();

      // steady push+pop at count 2 across pointer wrap
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_pc = 32'h400 + 32'(4*i); in_inst = $urandom;
         step();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_pc = 32'h500 + 32'(4*i); in_inst = $urandom;
         step();
      end
      chk("wrap_count", 64'(count), 64'd2);

      // flush with count 3 while pushing and popping
      out_ready = 1'b0; in_pc = 32'h600; in_inst = $urandom;
      step();
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h604;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();

      // asynchronous reset mid-cycle with count 2
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; in_pc = 32'h700 + 32'(4*i); in_inst = $urandom;
         step();
      end
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_count", 64'(count), 64'd0);
      q.delete();
      #1 rst = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'hC0DE_0300;
      step();
      in_valid = 1'b0;
      step();

      // empty queue, word offered with consumer ready (bypass vs registered path)
      out_ready = 1'b1; in_valid = 1'b0;
      step();
      in_valid = 1'b1; in_pc = 32'h200; in_inst = 32'hBEEF_0200;
      step();
      in_valid = 1'b0;
      step();

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if (!held) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_pc    = $urandom;
            in_inst  = $urandom;
         end
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 24) == 0);
         step();
      end
      flush = 1'b0; in_valid = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
